// File: rtl/fetch_stage.sv
// fetch_stage: IF stage of the 3-stage core.
// Owns the PC, drives the synchronous-read BIOS/IMEM ports and presents the
// decode-stage instruction. An EX-stage redirect (pc_sel == 1) nulls the
// wrong-path instruction in decode, leaving exactly one bubble.
// Optional build macro: FETCH_PERF_CNT_EN adds fetch_cnt/bubble_cnt outputs.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h4000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic [1:0]  pc_sel,
  input  logic [31:0] alu_result,
  output logic [11:0] bios_addr,
  output logic        bios_en,
  input  logic [31:0] bios_dout,
  output logic [13:0] imem_addr,
  output logic        imem_en,
  input  logic [31:0] imem_dout,
  output logic [31:0] fetch_addr,
  output logic [31:0] inst,
  output logic [31:0] pc_d,
  output logic [31:0] pc_x,
  output logic [31:0] pc_plus4_x
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] fetch_cnt,
  output logic [31:0] bubble_cnt
`endif
);

  typedef enum logic [1:0] {
    SRC_BIOS = 2'd0,
    SRC_IMEM = 2'd1,
    SRC_NONE = 2'd2
  } src_t;

  src_t src_d;
  src_t fetch_src;
  logic kill_d;
  logic redirect;
  logic unused_bits;

  // The low two target bits are forced to zero, so they are never consumed.
  assign unused_bits = ^alu_result[1:0];

  assign redirect = (pc_sel == 2'd1);

  // Next-PC selection; stall re-presents pc_d so the memory output stays stable.
  always_comb begin
    fetch_addr = pc_d + 32'd4;
    if (rst) begin
      fetch_addr = RESET_PC;
    end else if (stall) begin
      fetch_addr = pc_d;
    end else if (redirect) begin
      fetch_addr = {alu_result[31:2], 2'b00};
    end
  end

  // Address-map decode of the PC being fetched.
  always_comb begin
    fetch_src = SRC_NONE;
    if (fetch_addr[31:28] == 4'h4) begin
      fetch_src = SRC_BIOS;
    end else if (fetch_addr[31:28] == 4'h1) begin
      fetch_src = SRC_IMEM;
    end
  end

  assign bios_en    = (fetch_src == SRC_BIOS);
  assign imem_en    = (fetch_src == SRC_IMEM);
  assign bios_addr  = fetch_addr[13:2];
  assign imem_addr  = fetch_addr[15:2];
  assign pc_plus4_x = pc_x + 32'd4;

  // Decode-stage instruction: nulled after reset, on redirect, or when unmapped.
  always_comb begin
    inst = NOP_INST;
    if (!rst && !kill_d && !redirect) begin
      case (src_d)
        SRC_BIOS: inst = bios_dout;
        SRC_IMEM: inst = imem_dout;
        default:  inst = NOP_INST;
      endcase
    end
  end

  // IF/D and EX PC pipeline; everything freezes while stall is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_d   <= RESET_PC - 32'd4;
      pc_x   <= RESET_PC - 32'd4;
      src_d  <= SRC_BIOS;
      kill_d <= 1'b1;
    end else if (!stall) begin
      pc_d   <= fetch_addr;
      pc_x   <= pc_d;
      src_d  <= fetch_src;
      kill_d <= 1'b0;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic inst_live;

  assign inst_live = !kill_d && !redirect && (src_d != SRC_NONE);

  // Count real instructions handed to EX and redirect bubbles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt  <= 32'd0;
      bubble_cnt <= 32'd0;
    end else if (!stall) begin
      if (inst_live) begin
        fetch_cnt <= fetch_cnt + 32'd1;
      end
      if (redirect) begin
        bubble_cnt <= bubble_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus random
// redirect/stall/reset traffic, scored against a PC-stream reference model.
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h4000_0000;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic [1:0]  pc_sel = 2'd0;
  logic [31:0] alu_result = 32'd0;
  logic [11:0] bios_addr;
  logic        bios_en;
  logic [31:0] bios_dout = 32'd0;
  logic [13:0] imem_addr;
  logic        imem_en;
  logic [31:0] imem_dout = 32'd0;
  logic [31:0] fetch_addr;
  logic [31:0] inst;
  logic [31:0] pc_d;
  logic [31:0] pc_x;
  logic [31:0] pc_plus4_x;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt;
  logic [31:0] bubble_cnt;
`endif

  fetch_stage #(.RESET_PC(RESET_PC), .NOP_INST(NOP_INST)) dut (
    .clk(clk), .rst(rst), .stall(stall), .pc_sel(pc_sel), .alu_result(alu_result),
    .bios_addr(bios_addr), .bios_en(bios_en), .bios_dout(bios_dout),
    .imem_addr(imem_addr), .imem_en(imem_en), .imem_dout(imem_dout),
    .fetch_addr(fetch_addr), .inst(inst), .pc_d(pc_d), .pc_x(pc_x),
    .pc_plus4_x(pc_plus4_x)
`ifdef FETCH_PERF_CNT_EN
    , .fetch_cnt(fetch_cnt), .bubble_cnt(bubble_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] bios_word(input logic [11:0] idx);
    return (idx == 12'd0) ? 32'h0010_0093 : (32'hB000_0000 | {20'd0, idx});
  endfunction

  function automatic logic [31:0] imem_word(input logic [13:0] idx);
    return 32'hA000_0000 | {18'd0, idx};
  endfunction

  // Synchronous-read memories: data appears one cycle after the address.
  always @(posedge clk) begin
    if (bios_en) bios_dout <= bios_word(bios_addr);
    if (imem_en) imem_dout <= imem_word(imem_addr);
  end

  typedef struct packed {
    logic [31:0] fa;
    logic [31:0] inst;
    logic [31:0] pc_d;
    logic [31:0] pc_x;
    logic        bios_en;
    logic        imem_en;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  // Reference model: the PC in decode, the PC in EX, and whether decode holds a dead slot.
  logic [31:0] m_pc_d, m_pc_x, m_next;
  logic        m_kill;
  logic        cur_rst, cur_stall;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [31:0] model_inst(input logic [31:0] pc, input logic dead);
    if (dead) return NOP_INST;
    if (pc[31:28] == 4'h4) return bios_word(pc[13:2]);
    if (pc[31:28] == 4'h1) return imem_word(pc[15:2]);
    return NOP_INST;
  endfunction

  task automatic drive(input logic r, input logic s, input logic [1:0] sel, input logic [31:0] alu);
    exp_t e;
    rst = r; stall = s; pc_sel = sel; alu_result = alu;
    cur_rst = r; cur_stall = s;
    if (r) begin
      m_pc_d = RESET_PC - 32'd4;
      m_pc_x = RESET_PC - 32'd4;
      m_kill = 1'b1;
    end
    if (r)             e.fa = RESET_PC;
    else if (s)        e.fa = m_pc_d;
    else if (sel == 1) e.fa = {alu[31:2], 2'b00};
    else               e.fa = m_pc_d + 32'd4;
    m_next    = e.fa;
    e.inst    = model_inst(m_pc_d, r || m_kill || (sel == 2'd1));
    e.pc_d    = m_pc_d;
    e.pc_x    = m_pc_x;
    e.bios_en = (e.fa[31:28] == 4'h4);
    e.imem_en = (e.fa[31:28] == 4'h1);
    sb.push_back(e);
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    if (!cur_rst && !cur_stall) begin
      m_pc_x = m_pc_d;
      m_pc_d = m_next;
      m_kill = 1'b0;
    end
    #1;
  endtask

  // Monitor: compare every cycle's outputs against the queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("fetch_addr", fetch_addr, e.fa);
      chk("inst", inst, e.inst);
      chk("pc_d", pc_d, e.pc_d);
      chk("pc_x", pc_x, e.pc_x);
      chk("pc_plus4_x", pc_plus4_x, e.pc_x + 32'd4);
      chk("bios_en", {31'd0, bios_en}, {31'd0, e.bios_en});
      chk("imem_en", {31'd0, imem_en}, {31'd0, e.imem_en});
      chk("bios_addr", {20'd0, bios_addr}, {20'd0, e.fa[13:2]});
      chk("imem_addr", {18'd0, imem_addr}, {18'd0, e.fa[15:2]});
    end
  end

  initial begin
    logic [31:0] tgt;
    logic [1:0]  sel;
    int          k;
    cur_rst = 1'b1; cur_stall = 1'b0;
    m_pc_d = RESET_PC - 32'd4; m_pc_x = RESET_PC - 32'd4; m_kill = 1'b1; m_next = RESET_PC;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin drive(1, 0, 2'd0, 32'd0); tick(); end

    // Reset release and first BIOS word.
    drive(0, 0, 2'd0, 32'd0);
    chk("rel_fa", fetch_addr, 32'h4000_0000);
    chk("rel_inst", inst, NOP_INST);
    tick();
    drive(0, 0, 2'd0, 32'd0);
    chk("c1_inst", inst, 32'h0010_0093);
    chk("c1_pc_d", pc_d, 32'h4000_0000);
    chk("c1_fa", fetch_addr, 32'h4000_0004);
    tick();
    drive(0, 0, 2'd0, 32'd0); tick();

    // Redirect from pc_d=0x40000008 into IMEM.
    drive(0, 0, 2'd1, 32'h1000_0010);
    chk("redir_pc_d", pc_d, 32'h4000_0008);
    chk("redir_inst", inst, NOP_INST);
    tick();
    drive(0, 0, 2'd0, 32'd0);
    chk("tgt_pc_d", pc_d, 32'h1000_0010);
    chk("tgt_inst", inst, imem_word(14'h004));
    tick();

    // Back to 0x40000004, then stall three cycles.
    drive(0, 0, 2'd1, 32'h4000_0004); tick();
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 2'd0, 32'd0);
      chk("stall_fa", fetch_addr, 32'h4000_0004);
      tick();
    end
    drive(0, 0, 2'd0, 32'd0); tick();
    drive(0, 0, 2'd0, 32'd0);
    chk("unstall_pc_d", pc_d, 32'h4000_0008);
    tick();

    // Stall and redirect together: stall wins until release.
    for (int i = 0; i < 2; i++) begin
      drive(0, 1, 2'd1, 32'h4000_0100);
      chk("stsel_inst", inst, NOP_INST);
      tick();
    end
    drive(0, 0, 2'd1, 32'h4000_0100);
    chk("stsel_fa", fetch_addr, 32'h4000_0100);
    tick();
    drive(0, 0, 2'd0, 32'd0); tick();

    // Unmapped region, PC wrap, then asynchronous reset mid-cycle.
    drive(0, 0, 2'd1, 32'h2000_0000); tick();
    drive(0, 0, 2'd0, 32'd0);
    chk("unmap_inst", inst, NOP_INST);
    tick();
    drive(0, 0, 2'd1, 32'hFFFF_FFFC); tick();
    drive(0, 0, 2'd0, 32'd0);
    chk("wrap_fa", fetch_addr, 32'h0000_0000);
    tick();
    drive(1, 0, 2'd0, 32'd0);
    chk("arst_fa", fetch_addr, 32'h4000_0000);
    chk("arst_pc_x", pc_x, 32'h3FFF_FFFC);
    tick();

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      k = $urandom_range(0, 3);
      case (k)
        0: tgt = 32'h4000_0000 | ($urandom & 32'h0000_3FFF);
        1: tgt = 32'h1000_0000 | ($urandom & 32'h0000_FFFF);
        2: tgt = 32'h2000_0000 | ($urandom & 32'h0000_00FF);
        default: tgt = $urandom;
      endcase
      sel = ($urandom_range(0, 4) == 0) ? 2'd1 : (($urandom_range(0, 1) == 0) ? 2'd0 : 2'd2);
      drive(($urandom_range(0, 39) == 0), ($urandom_range(0, 4) == 0), sel, tgt);
      tick();
    end
    drive(0, 0, 2'd0, 32'd0); tick();

    for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
IF stage of the 3-stage core: owns the PC, drives the synchronous-read BIOS and IMEM ports, and presents the decode-stage instruction to the controller and datapath. It takes the EX-stage redirect (PCSel plus ALU target) and inserts one NOP bubble per taken branch or jump. It also carries the PC of the instruction in decode and in EX for AUIPC/JAL/JALR.

Parameters:
RESET_PC, 32'h4000_0000, PC fetched in the first cycle after reset (BIOS base).
NOP_INST, 32'h0000_0013, bubble instruction (addi x0,x0,0).

Ports:
clk  in  1  core clock
rst  in  1  reset; one clock, asynchronous, active-high
stall  in  1  freeze IF/D and EX (PC, pc_d, pc_x hold)
pc_sel  in  2  from controller: 1 = redirect to alu_result; 0 or 2 = sequential
alu_result  in  32  redirect target computed in EX
bios_addr  out  12  BIOS word address = fetch_addr[13:2]
bios_en  out  1  fetch_addr[31:28]==4'h4
bios_dout  in  32  BIOS read data, valid 1 cycle after address
imem_addr  out  14  IMEM word address = fetch_addr[15:2]
imem_en  out  1  fetch_addr[31:28]==4'h1
imem_dout  in  32  IMEM read data, valid 1 cycle after address
fetch_addr  out  32  PC being fetched this cycle (combinational next-PC)
inst  out  32  instruction in decode
pc_d  out  32  PC of inst
pc_x  out  32  PC of instruction in EX
pc_plus4_x  out  32  pc_x + 4, mod 2^32

Behaviour:
- Registers: pc_d, pc_x, src_d (2-bit: BIOS/IMEM/unmapped, latched from fetch_addr[31:28]), kill_d.
- Reset (async): pc_d = RESET_PC-4, pc_x = RESET_PC-4, src_d = BIOS, kill_d = 1. While rst is high: fetch_addr = RESET_PC, inst = NOP_INST.
- fetch_addr priority: stall → pc_d (re-read so memory dout stays stable); else pc_sel==1 → {alu_result[31:2],2'b00}; else pc_d+4.
- Each edge with !stall: pc_d <= fetch_addr, src_d <= region(fetch_addr), pc_x <= pc_d, kill_d <= 0.
- inst (combinational): NOP_INST if kill_d, or pc_sel==1, or src_d==unmapped; otherwise bios_dout or imem_dout per src_d.
- Redirect: the wrong-path instruction in decode during the pc_sel==1 cycle is nulled in that same cycle. Target reaches decode next cycle. Exactly one bubble.
- First cycle after reset release: inst = NOP (kill_d), fetch_addr = RESET_PC; the RESET_PC instruction is in decode one cycle later.
- stall && pc_sel==1: stall wins. PC holds, inst stays NOP; redirect is taken on the first cycle with stall=0 (pc_sel still asserted, EX frozen).
- Unmapped region: bios_en = imem_en = 0, inst = NOP. PC still advances by 4.
- PC wrap 0xFFFF_FFFC → 0x0000_0000, no flag.
- No combinational path from inst to pc_sel inside this block. The controller decodes pc_sel from the EX instruction only.

Optional Feature:
FETCH_PERF_CNT_EN. When defined, the block adds outputs fetch_cnt[31:0] and bubble_cnt[31:0], both reset to 0 and wrapping at 2^32.
- fetch_cnt increments on each !stall edge where inst != killed (real instruction handed to EX).
- bubble_cnt increments on each !stall edge with pc_sel==1.
When the macro is not defined, the ports and logic are absent and the behaviour is otherwise identical.

Test Plan:
- Reset release, bios_dout returns 0x00100093 for word 0 → cycle 0: fetch_addr=0x40000000, inst=NOP; cycle 1: inst=0x00100093, pc_d=0x40000000, fetch_addr=0x40000004.
- Sequential run of 4 instructions → pc_d 0x40000000..0x4000000C, pc_x lags by one cycle, pc_plus4_x = pc_x+4.
- pc_sel=1, alu_result=0x10000010 while pc_d=0x40000008 → inst=NOP that cycle; next cycle pc_d=0x10000010, imem_en=1, imem_addr=0x004, inst=imem_dout.
- stall held 3 cycles at pc_d=0x40000004 → fetch_addr=0x40000004 throughout, pc_d/pc_x/inst unchanged; release → pc_d=0x40000008.
- stall=1 and pc_sel=1 together for 2 cycles, then stall=0 → PC holds and inst=NOP for both cycles; redirect to alu_result on the release edge; with FETCH_PERF_CNT_EN, bubble_cnt +1 only.
- Redirect to 0x20000000 → bios_en=imem_en=0, inst=NOP; assert rst mid-run → fetch_addr=0x40000000 immediately, pc_x=0x3FFFFFFC asynchronously.
